// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern-detection controller.
//   - state_e          : controller FSM states
//   - calc_len_w()     : width of a pattern-length field for a given maximum length
//   - EVT_CAUSE_*      : encodings of the completion-event cause bit
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_e;

    localparam logic EVT_CAUSE_TARGET  = 1'b0;
    localparam logic EVT_CAUSE_TIMEOUT = 1'b1;

    // One extra bit so that MAX_LEN itself is representable.
    function automatic int unsigned calc_len_w(input int unsigned max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/seq_det_controller_if.sv
// Host-side configuration and completion-event handshake bundle.
//   cfg_*  : valid/ready config offer (pattern, length, overlap, target, timeout)
//   evt_*  : valid/ready completion event with its cause bit
//   master : host side, slave : controller side
interface seq_det_controller_if
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TMO_W   = 16
);
    localparam int unsigned LEN_W = calc_len_w(MAX_LEN);

    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic [TMO_W-1:0]   cfg_timeout;

    logic               evt_valid;
    logic               evt_ready;
    logic               evt_timeout;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
        output evt_ready,
        input  cfg_ready, evt_valid, evt_timeout
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
        input  evt_ready,
        output cfg_ready, evt_valid, evt_timeout
    );

endinterface

// File: rtl/seq_match_core.sv
// Mealy bit-pattern matcher: history shift register, fill counter and masked compare.
//   clear     : synchronous clear of history and fill
//   bit_valid : qualifies input_bit (no shift, no match when low)
//   pattern   : bit 0 is compared against the newest bit
//   len       : number of low pattern bits that take part in the compare
//   overlap   : 0 = a match restarts the fill so the next match needs len fresh bits
//   detected  : combinational, asserted in the cycle of the matching bit
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = calc_len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               bit_valid,
    input  logic               input_bit,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               detected
);

    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_d;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_d;

    // Candidate window including the bit arriving this cycle.
    always_comb begin
        hist_d = {hist_q[MAX_LEN-2:0], input_bit};
        fill_d = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        detected = bit_valid && (fill_d >= len) && (((hist_d ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clear) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (bit_valid) begin
            hist_q <= hist_d;
            fill_q <= (detected && !overlap) ? '0 : fill_d;
        end
    end

endmodule

// File: rtl/seq_det_controller.sv
// Serial pattern-detection controller: latches config, runs a scan on the matcher,
// counts matches and posts one completion event (target reached or timeout).
//   clk, reset  : clock, asynchronous active-high reset
//   bus         : config offer / completion event handshakes (slave side)
//   start/abort : begin a scan from IDLE / drop back to IDLE without an event
//   bit_valid, input_bit : qualified serial stream
//   detected    : combinational Mealy match pulse
//   busy        : controller not in IDLE
//   match_count : matches in the current or last scan
// Build option SEQ_DET_CTRL_TIMEOUT_EN: adds the scan timeout counter; without it
// cfg_timeout has no effect, evt_timeout is 0 and a scan ends on target or abort.
module seq_det_controller
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TMO_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_det_controller_if.slave  bus,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 bit_valid,
    input  logic                 input_bit,
    output logic                 detected,
    output logic                 busy,
    output logic [CNT_W-1:0]     match_count
);

    localparam int unsigned LEN_W = calc_len_w(MAX_LEN);

    state_e             state;
    state_e             state_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q;
    logic [CNT_W-1:0]   count_d;
    logic [CNT_W-1:0]   count_inc;
    logic [CNT_W-1:0]   tgt_eff;
    logic               cfg_fire;
    logic               len_legal;
    logic               core_clear;
    logic               core_bit_valid;

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    logic [TMO_W-1:0]   tmo_q;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [TMO_W-1:0]   tmo_cnt_d;
    logic               tmo_hit;
    logic               evt_timeout_q;
    logic               cause_d;
`endif

    assign bus.cfg_ready = (state == IDLE) && !start;
    assign bus.evt_valid = (state == REPORT);
    assign busy          = (state != IDLE);
    assign cfg_fire      = bus.cfg_valid && bus.cfg_ready;
    assign len_legal     = (len_q != '0) && (len_q <= LEN_W'(MAX_LEN));
    assign count_inc     = (match_count == '1) ? match_count : match_count + CNT_W'(1);
    assign tgt_eff       = (tgt_q == '0) ? CNT_W'(1) : tgt_q;
    // Stream is only looked at while scanning; REPORT ignores bit_valid.
    assign core_bit_valid = bit_valid && (state == SCAN);

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    assign tmo_hit         = (tmo_q != '0) && ((tmo_cnt + TMO_W'(1)) == tmo_q);
    assign bus.evt_timeout = evt_timeout_q;
`else
    assign bus.evt_timeout = EVT_CAUSE_TARGET;
`endif

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .clear     (core_clear),
        .bit_valid (core_bit_valid),
        .input_bit (input_bit),
        .pattern   (pat_q),
        .len       (len_q),
        .overlap   (ovl_q),
        .detected  (detected)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Next state and counter updates; a match beats a timeout in the same cycle.
    always_comb begin
        state_d    = state;
        count_d    = match_count;
        core_clear = 1'b0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        cause_d    = evt_timeout_q;
        tmo_cnt_d  = tmo_cnt;
`endif
        case (state)
            IDLE: begin
                if (start && len_legal) begin
                    state_d    = SCAN;
                    count_d    = '0;
                    core_clear = 1'b1;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                    cause_d    = EVT_CAUSE_TARGET;
                    tmo_cnt_d  = '0;
`endif
                end
            end
            SCAN: begin
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt + TMO_W'(1);
`endif
                if (detected) count_d = count_inc;
                if (detected && (count_inc >= tgt_eff)) begin
                    state_d = REPORT;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                    cause_d = EVT_CAUSE_TARGET;
                end else if (tmo_hit) begin
                    state_d = REPORT;
                    cause_d = EVT_CAUSE_TIMEOUT;
`endif
                end
            end
            REPORT: begin
                if (bus.evt_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides everything outside IDLE; the count keeps its last value.
        if (abort && (state != IDLE)) begin
            state_d = IDLE;
            count_d = match_count;
        end
    end

    // Latched configuration and match counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q       <= '0;
            len_q       <= LEN_W'(1);
            ovl_q       <= 1'b1;
            tgt_q       <= CNT_W'(1);
            match_count <= '0;
        end else begin
            if (cfg_fire) begin
                pat_q <= bus.cfg_pattern;
                len_q <= bus.cfg_len;
                ovl_q <= bus.cfg_overlap;
                tgt_q <= bus.cfg_target;
            end
            match_count <= count_d;
        end
    end

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    // Timeout limit, scan-cycle counter and event cause.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q         <= '0;
            tmo_cnt       <= '0;
            evt_timeout_q <= 1'b0;
        end else begin
            if (cfg_fire) tmo_q <= bus.cfg_timeout;
            tmo_cnt       <= tmo_cnt_d;
            evt_timeout_q <= cause_d;
        end
    end
`endif

endmodule

// File: tb/tb_seq_det_controller.sv
// Directed self-checking bench for seq_det_controller.
// Patterns are written with bit 0 = newest bit, so the stream 1,1,0,1 is 4'b1101.
module tb_seq_det_controller;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TMO_W   = 16;

    logic clk;
    logic reset;
    logic start;
    logic abort;
    logic bit_valid;
    logic input_bit;
    logic detected;
    logic busy;
    logic [CNT_W-1:0] match_count;

    int checks;
    int errors;

    seq_det_controller_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TMO_W(TMO_W)) bus ();

    seq_det_controller #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .start       (start),
        .abort       (abort),
        .bit_valid   (bit_valid),
        .input_bit   (input_bit),
        .detected    (detected),
        .busy        (busy),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus drivers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, output logic det);
        bit_valid = 1'b1;
        input_bit = b;
        #1;
        det = detected;
        tick();
        bit_valid = 1'b0;
        input_bit = 1'b0;
    endtask

    task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                            input logic [15:0] tgt, input logic [15:0] tmo);
        bus.cfg_valid   = 1'b1;
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_overlap = ovl;
        bus.cfg_target  = tgt;
        bus.cfg_timeout = tmo;
        tick();
        bus.cfg_valid   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic ack_event();
        bus.evt_ready = 1'b1;
        tick();
        bus.evt_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b expected 1", bus.cfg_ready); end
        checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_evt_valid: got %b expected 0", bus.evt_valid); end
        checks++; if (bus.evt_timeout !== 1'b0) begin errors++; $display("FAIL reset_evt_timeout: got %b expected 0", bus.evt_timeout); end
        checks++; if (match_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", match_count); end
        checks++; if (detected !== 1'b0) begin errors++; $display("FAIL reset_detected: got %b expected 0", detected); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_overlap();
        logic [6:0] s;
        logic [6:0] e;
        logic det;
        s = 7'b1101101;
        e = 7'b0001001;
        load_cfg(8'h0D, 4'd4, 1'b1, 16'd2, 16'd0);
        do_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovl_busy_after_start: got %b expected 1", busy); end
        for (int i = 6; i >= 0; i--) begin
            drive_bit(s[i], det);
            checks++;
            if (det !== e[i]) begin errors++; $display("FAIL ovl_detected bit%0d: got %b expected %b", 7 - i, det, e[i]); end
        end
        checks++; if (bus.evt_valid !== 1'b1) begin errors++; $display("FAIL ovl_evt_valid: got %b expected 1", bus.evt_valid); end
        checks++; if (bus.evt_timeout !== 1'b0) begin errors++; $display("FAIL ovl_evt_timeout: got %b expected 0", bus.evt_timeout); end
        checks++; if (match_count !== 16'd2) begin errors++; $display("FAIL ovl_count: got %0d expected 2", match_count); end
        ack_event();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovl_idle_after_ack: got busy %b expected 0", busy); end
        checks++; if (match_count !== 16'd2) begin errors++; $display("FAIL ovl_count_retained: got %0d expected 2", match_count); end
    endtask

    task automatic test_no_overlap();
        logic [10:0] s;
        logic [10:0] e;
        logic det;
        s = 11'b11011011101;
        e = 11'b00010000001;
        load_cfg(8'h0D, 4'd4, 1'b0, 16'd2, 16'd0);
        do_start();
        for (int i = 10; i >= 0; i--) begin
            drive_bit(s[i], det);
            checks++;
            if (det !== e[i]) begin errors++; $display("FAIL novl_detected bit%0d: got %b expected %b", 11 - i, det, e[i]); end
            if (i == 4) begin
                checks++;
                if (match_count !== 16'd1) begin errors++; $display("FAIL novl_count_after7: got %0d expected 1", match_count); end
            end
        end
        checks++; if (bus.evt_valid !== 1'b1) begin errors++; $display("FAIL novl_evt_valid: got %b expected 1", bus.evt_valid); end
        checks++; if (match_count !== 16'd2) begin errors++; $display("FAIL novl_count: got %0d expected 2", match_count); end
        ack_event();
    endtask

    task automatic test_timeout();
        logic det;
        logic exp_v;
        load_cfg(8'h0D, 4'd4, 1'b1, 16'd5, 16'd10);
        do_start();
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        // Mix of zero bits and idle cycles; the counter advances on both.
        for (int k = 1; k <= 10; k++) begin
            if (k % 2 == 1) drive_bit(1'b0, det);
            else            tick();
            exp_v = (k == 10);
            checks++;
            if (bus.evt_valid !== exp_v) begin errors++; $display("FAIL tmo_evt_valid cycle%0d: got %b expected %b", k, bus.evt_valid, exp_v); end
        end
        checks++; if (bus.evt_timeout !== 1'b1) begin errors++; $display("FAIL tmo_evt_timeout: got %b expected 1", bus.evt_timeout); end
        checks++; if (match_count !== 16'd0) begin errors++; $display("FAIL tmo_count: got %0d expected 0", match_count); end
        ack_event();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle_after_ack: got busy %b expected 0", busy); end
`else
        for (int k = 1; k <= 20; k++) begin
            drive_bit(1'b0, det);
            checks++;
            if (bus.evt_valid !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL notmo_still_scanning cycle%0d: got evt_valid %b busy %b expected 0 1", k, bus.evt_valid, busy);
            end
        end
        exp_v = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== exp_v) begin errors++; $display("FAIL notmo_abort_idle: got busy %b expected 0", busy); end
`endif
    endtask

    task automatic test_match_timeout_tie();
        logic [3:0] s;
        logic det;
        s = 4'b1101;
        load_cfg(8'h0D, 4'd4, 1'b1, 16'd1, 16'd4);
        do_start();
        for (int i = 3; i >= 0; i--) begin
            drive_bit(s[i], det);
            checks++;
            if (det !== (i == 0)) begin errors++; $display("FAIL tie_detected bit%0d: got %b expected %b", 4 - i, det, (i == 0)); end
        end
        checks++; if (bus.evt_valid !== 1'b1) begin errors++; $display("FAIL tie_evt_valid: got %b expected 1", bus.evt_valid); end
        checks++; if (bus.evt_timeout !== 1'b0) begin errors++; $display("FAIL tie_evt_timeout: got %b expected 0", bus.evt_timeout); end
        checks++; if (match_count !== 16'd1) begin errors++; $display("FAIL tie_count: got %0d expected 1", match_count); end
    endtask

    // Entered with an event pending from test_match_timeout_tie.
    task automatic test_report_hold_and_abort();
        logic [4:0] s;
        logic [3:0] m;
        logic det;
        s = 5'b11011;
        m = 4'b1101;
        for (int i = 4; i >= 0; i--) begin
            drive_bit(s[i], det);
            checks++;
            if (det !== 1'b0 || bus.evt_valid !== 1'b1 || bus.evt_timeout !== 1'b0 || match_count !== 16'd1) begin
                errors++;
                $display("FAIL hold_stable cycle%0d: got det %b evt_valid %b evt_timeout %b count %0d expected 0 1 0 1",
                         5 - i, det, bus.evt_valid, bus.evt_timeout, match_count);
            end
        end
        ack_event();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_idle_after_ack: got busy %b expected 0", busy); end
        do_start();
        for (int i = 3; i >= 0; i--) drive_bit(m[i], det);
        checks++; if (bus.evt_valid !== 1'b1) begin errors++; $display("FAIL abort_pre_evt_valid: got %b expected 1", bus.evt_valid); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || bus.evt_valid !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy %b evt_valid %b expected 0 0", busy, bus.evt_valid); end
        checks++; if (match_count !== 16'd1) begin errors++; $display("FAIL abort_count_retained: got %0d expected 1", match_count); end
    endtask

    task automatic test_illegal_len();
        load_cfg(8'h0D, 4'd0, 1'b1, 16'd1, 16'd0);
        do_start();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_ignored: got busy %b expected 0", busy); end
        load_cfg(8'h0D, 4'd9, 1'b1, 16'd1, 16'd0);
        do_start();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len9_ignored: got busy %b expected 0", busy); end
    endtask

    task automatic test_cfg_start_collision();
        logic [3:0] s;
        logic det;
        s = 4'b1101;
        load_cfg(8'h0D, 4'd4, 1'b1, 16'd1, 16'd0);
        // New config offered together with start: must be refused.
        bus.cfg_valid   = 1'b1;
        bus.cfg_pattern = 8'h00;
        bus.cfg_len     = 4'd2;
        start           = 1'b1;
        #1;
        checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL coll_cfg_ready: got %b expected 0", bus.cfg_ready); end
        tick();
        start         = 1'b0;
        bus.cfg_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL coll_busy: got %b expected 1", busy); end
        for (int i = 3; i >= 0; i--) begin
            drive_bit(s[i], det);
            checks++;
            if (det !== (i == 0)) begin errors++; $display("FAIL coll_old_cfg_detected bit%0d: got %b expected %b", 4 - i, det, (i == 0)); end
        end
        ack_event();
    endtask

    task automatic test_reset_mid_scan();
        logic [3:0] s;
        logic det;
        s = 4'b1101;
        load_cfg(8'h0D, 4'd4, 1'b1, 16'd3, 16'd0);
        do_start();
        for (int i = 3; i >= 0; i--) drive_bit(s[i], det);
        checks++; if (match_count !== 16'd1) begin errors++; $display("FAIL rst_pre_count: got %0d expected 1", match_count); end
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || bus.evt_valid !== 1'b0 || match_count !== 16'd0 || bus.cfg_ready !== 1'b1 || bus.evt_timeout !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_scan: got busy %b evt_valid %b count %0d cfg_ready %b evt_timeout %b expected 0 0 0 1 0",
                     busy, bus.evt_valid, match_count, bus.cfg_ready, bus.evt_timeout);
        end
        tick();
        reset = 1'b0;
        tick();
        // Reset config: pattern 0, len 1, target 1 -> a single 0 bit completes a scan.
        do_start();
        drive_bit(1'b0, det);
        checks++; if (det !== 1'b1) begin errors++; $display("FAIL rst_default_cfg_detected: got %b expected 1", det); end
        checks++; if (bus.evt_valid !== 1'b1 || match_count !== 16'd1) begin errors++; $display("FAIL rst_default_cfg_event: got evt_valid %b count %0d expected 1 1", bus.evt_valid, match_count); end
        ack_event();
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        start           = 1'b0;
        abort           = 1'b0;
        bit_valid       = 1'b0;
        input_bit       = 1'b0;
        bus.cfg_valid   = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_overlap = 1'b0;
        bus.cfg_target  = '0;
        bus.cfg_timeout = '0;
        bus.evt_ready   = 1'b0;

        test_reset();
        test_overlap();
        test_no_overlap();
        test_timeout();
        test_match_timeout_tie();
        test_report_hold_and_abort();
        test_illegal_len();
        test_cfg_start_collision();
        test_reset_mid_scan();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
